delay_mod_ctrl: RTL and testbench

// Sequencer and modulation controller in front of DelayBufferFSM (chorus/flanger path).
// - Accepts one audio sample per strobe and runs a triangle LFO once per sample.
// - Computes the modulated extra delay and presents sample + delay to the delay buffer.
// - Waits for the buffer's delayed-output strobe before accepting the next sample.

---
 rtl/delay_mod_ctrl.sv | 167 ++++++++++++++++
 tb/tb_delay_mod_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_mod_ctrl.sv
// Sequencer and triangle-LFO delay modulator in front of the delay buffer.
// Ports: clk/rst; sample in (pkt_reg_i, pktChanged_reg_i); modulation
// control (enable_reg_i, rate_reg_i, depth_reg_i, cfgValid_reg_i); buffer
// side (pkt_reg_o, pktChanged_reg_o, extraDelay_reg_o,
// pktDelayedChanged_reg_i); status (busy_reg_o, overrun_reg_o,
// timeout_reg_o). Define DELAY_MOD_SLEW_EN to slew extraDelay_reg_o by at
// most one sample per transaction.
module delay_mod_ctrl #(
  parameter int PKT_WIDTH       = 16,
  parameter int ADDR_WIDTH      = 14,
  parameter int PHASE_WIDTH     = 24,
  parameter int MAX_EXTRA_DELAY = 441,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PKT_WIDTH-1:0]   pkt_reg_i,
  input  logic                   pktChanged_reg_i,
  input  logic                   enable_reg_i,
  input  logic [PHASE_WIDTH-1:0] rate_reg_i,
  input  logic [ADDR_WIDTH-1:0]  depth_reg_i,
  input  logic                   cfgValid_reg_i,
  output logic [PKT_WIDTH-1:0]   pkt_reg_o,
  output logic                   pktChanged_reg_o,
  output logic [ADDR_WIDTH-1:0]  extraDelay_reg_o,
  input  logic                   pktDelayedChanged_reg_i,
  output logic                   busy_reg_o,
  output logic                   overrun_reg_o,
  output logic                   timeout_reg_o
);

  localparam int PW = PHASE_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] MAXD = AW'(MAX_EXTRA_DELAY);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT
  } state_t;

  state_t         state;
  logic [PKT_WIDTH-1:0] pkt_q;
  logic [PW-1:0]  phase;
  logic [PW-1:0]  rate;
  logic [AW-1:0]  depth;
  logic [PW-1:0]  pend_rate;
  logic [AW-1:0]  pend_depth;
  logic           pend_valid;
  logic [AW-1:0]  target;
  logic [CW-1:0]  cnt;

  logic [PW-1:0]  rate_eff;
  logic [PW-1:0]  phase_nxt;
  logic [AW-1:0]  pend_clip;
  logic [AW-1:0]  depth_eff;
  logic [PW-2:0]  tri_w;
  logic [9:0]     t10;
  logic [AW+9:0]  prod;
  logic [AW-1:0]  prod_sh;
  logic [AW-1:0]  target_nxt;
  logic [AW-1:0]  delay_nxt;

  always_comb begin
    pend_clip  = (pend_depth > MAXD) ? MAXD : pend_depth;
    rate_eff   = pend_valid ? pend_rate : rate;
    depth_eff  = pend_valid ? pend_clip : depth;
    phase_nxt  = enable_reg_i ? phase + rate_eff : phase;
    // Fold the upper half of the ramp to make a triangle.
    tri_w      = phase_nxt[PW-1] ? ~phase_nxt[PW-2:0]
                                 : phase_nxt[PW-2:0];
    t10        = tri_w[PW-2:PW-11];
    prod       = {{AW{1'b0}}, t10} * {10'd0, depth_eff};
    prod_sh    = prod[AW+9:10];
    target_nxt = '0;
    if (enable_reg_i)
      target_nxt = (prod_sh > MAXD) ? MAXD : prod_sh;
  end

`ifdef DELAY_MOD_SLEW_EN
  always_comb begin
    delay_nxt = extraDelay_reg_o;
    if (target > extraDelay_reg_o)
      delay_nxt = extraDelay_reg_o + AW'(1);
    else if (target < extraDelay_reg_o)
      delay_nxt = extraDelay_reg_o - AW'(1);
  end
`else
  always_comb begin
    delay_nxt = target;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pkt_q            <= '0;
      phase            <= '0;
      rate             <= '0;
      depth            <= '0;
      pend_rate        <= '0;
      pend_depth       <= '0;
      pend_valid       <= 1'b0;
      target           <= '0;
      cnt              <= '0;
      pkt_reg_o        <= '0;
      pktChanged_reg_o <= 1'b0;
      extraDelay_reg_o <= '0;
      busy_reg_o       <= 1'b0;
      overrun_reg_o    <= 1'b0;
      timeout_reg_o    <= 1'b0;
    end else begin
      pktChanged_reg_o <= 1'b0;
      if (pktChanged_reg_i && state != IDLE)
        overrun_reg_o <= 1'b1;
      unique case (state)
        IDLE: begin
          if (pktChanged_reg_i) begin
            pkt_q      <= pkt_reg_i;
            busy_reg_o <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          if (pend_valid) begin
            rate       <= pend_rate;
            depth      <= pend_clip;
            pend_valid <= 1'b0;
          end
          phase  <= phase_nxt;
          target <= target_nxt;
          state  <= ISSUE;
        end
        ISSUE: begin
          pktChanged_reg_o <= 1'b1;
          pkt_reg_o        <= pkt_q;
          extraDelay_reg_o <= delay_nxt;
          cnt              <= '0;
          state            <= WAIT;
        end
        WAIT: begin
          if (pktDelayedChanged_reg_i) begin
            busy_reg_o <= 1'b0;
            state      <= IDLE;
          end else if (cnt == TLAST) begin
            timeout_reg_o <= 1'b1;
            busy_reg_o    <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // A strobe landing in CALC stays pending for the next CALC.
      if (cfgValid_reg_i) begin
        pend_rate  <= rate_reg_i;
        pend_depth <= depth_reg_i;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_mod_ctrl.sv
// Directed scoreboard bench for delay_mod_ctrl (default build).
// Drives on negedge, samples on negedge after the active posedge.
module tb_delay_mod_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pkt_i;
  logic        strb_i;
  logic        en_i;
  logic [23:0] rate_i;
  logic [13:0] depth_i;
  logic        cfg_i;
  logic [15:0] pkt_o;
  logic        strb_o;
  logic [13:0] dly_o;
  logic        ack_i;
  logic        busy_o;
  logic        ovr_o;
  logic        tmo_o;

  delay_mod_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .pkt_reg_i               (pkt_i),
    .pktChanged_reg_i        (strb_i),
    .enable_reg_i            (en_i),
    .rate_reg_i              (rate_i),
    .depth_reg_i             (depth_i),
    .cfgValid_reg_i          (cfg_i),
    .pkt_reg_o               (pkt_o),
    .pktChanged_reg_o        (strb_o),
    .extraDelay_reg_o        (dly_o),
    .pktDelayedChanged_reg_i (ack_i),
    .busy_reg_o              (busy_o),
    .overrun_reg_o           (ovr_o),
    .timeout_reg_o           (tmo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pkt;
    logic [13:0] d;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errs   = 0;
  int n_out  = 0;
  int issued = 0;

  // Bench-side model of the modulator.
  logic [23:0] ph;
  int          m_rate;
  int          m_dep;
  int          p_rate;
  int          p_dep;
  bit          p_val;

  always @(negedge clk) if (!rst && strb_o) n_out++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int model(input logic [23:0] p, input int dep);
    logic [22:0] t;
    int t10;
    int r;
    t   = p[23] ? ~p[22:0] : p[22:0];
    t10 = int'(t >> 13);
    r   = (t10 * dep) / 1024;
    if (r > 441) r = 441;
    return r;
  endfunction

  // Advance the model by one CALC and return the expected delay.
  function automatic int next_d();
    if (p_val) begin
      m_rate = p_rate;
      m_dep  = (p_dep > 441) ? 441 : p_dep;
      p_val  = 0;
    end
    if (!en_i) return 0;
    ph = ph + 24'(m_rate);
    return model(ph, m_dep);
  endfunction

  task automatic cfg(input int r, input int d);
    @(negedge clk);
    rate_i  = 24'(r);
    depth_i = 14'(d);
    cfg_i   = 1'b1;
    @(negedge clk);
    cfg_i   = 1'b0;
    p_rate  = r;
    p_dep   = d;
    p_val   = 1;
  endtask

  task automatic strobe(input logic [15:0] p);
    @(negedge clk);
    pkt_i  = p;
    strb_i = 1'b1;
    @(negedge clk);
    strb_i = 1'b0;
  endtask

  // Send a sample; returns at the negedge where pktChanged_reg_o is high.
  task automatic issue(input logic [15:0] p, input int d);
    exp_t e;
    int k;
    e.pkt = p;
    e.d   = 14'(d);
    sb.push_back(e);
    issued++;
    strobe(p);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!strb_o && k < 10);
    chk("latency", k, 2);
    e = sb.pop_front();
    chk("extra_delay", dly_o, e.d);
    chk("pkt_out", pkt_o, e.pkt);
  endtask

  task automatic ack(input int n);
    int k;
    repeat (n) @(negedge clk);
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    k = 0;
    while (busy_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("busy_after_ack", busy_o, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pkt"}, pkt_o, 0);
    chk({tag, "_strb"}, strb_o, 0);
    chk({tag, "_dly"}, dly_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ovr"}, ovr_o, 0);
    chk({tag, "_tmo"}, tmo_o, 0);
  endtask

  int sweep [16] = '{50, 100, 150, 200, 250, 300, 350, 399,
                     349, 299, 249, 199, 149, 99, 49, 0};

  initial begin
    int k;
    rst = 1'b1; pkt_i = '0; strb_i = 1'b0; en_i = 1'b1;
    rate_i = '0; depth_i = '0; cfg_i = 1'b0; ack_i = 1'b0;
    ph = '0; m_rate = 0; m_dep = 0; p_rate = 0; p_dep = 0; p_val = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Sweep: one full LFO period.
    cfg(24'h100000, 400);
    for (int i = 0; i < 16; i++) begin
      void'(next_d());
      issue(16'hA000 + 16'(i), sweep[i]);
      ack(5);
    end
    chk("sweep_phase_wrap", ph, 0);
    chk("no_overrun", ovr_o, 0);

    // Overrun: second strobe while waiting is dropped.
    issue(16'hB001, next_d());
    strobe(16'hB002);
    chk("overrun_set", ovr_o, 1);
    ack(3);
    repeat (5) @(negedge clk);
    chk("dropped_count", n_out, issued);
    issue(16'hB003, next_d());
    chk("dropped_no_phase", dly_o, 100);
    ack(5);
    chk("overrun_sticky", ovr_o, 1);

    // Timeout: never acknowledge.
    issue(16'hC001, next_d());
    k = 0;
    while (busy_o && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", k, 4096);
    chk("timeout_set", tmo_o, 1);
    issue(16'hC002, next_d());
    ack(5);
    chk("timeout_sticky", tmo_o, 1);

    // Config during WAIT does not disturb the current delay.
    issue(16'hD001, next_d());
    cfg(24'h100000, 1000);
    chk("cfg_hold", dly_o, 250);
    ack(2);
    issue(16'hD002, next_d());
    chk("depth_clip", dly_o, 330);
    ack(5);
    en_i = 1'b0;
    issue(16'hD003, next_d());
    ack(5);
    en_i = 1'b1;
    issue(16'hD004, next_d());
    chk("phase_frozen", dly_o, 385);
    ack(5);

    // Reset in the middle of WAIT.
    issue(16'hE001, next_d());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("midwait_reset");
    rst = 1'b0;
    ph = '0; m_rate = 0; m_dep = 0; p_val = 0;
    cfg(24'h100000, 400);
    issue(16'hE002, next_d());
    chk("restart_phase0", dly_o, 50);
    ack(5);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
